// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier, unsigned or two's-complement, full 2*WIDTH product.
// Latency: DONE pulses WIDTH+1 cycles after START is sampled; START is ignored while BUSY.
// Backpressure: none downstream; the requester stalls on BUSY, and RESULT/OVERFLOW hold until the next DONE.
module mult_seq #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 SIGNED,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   RESULT,
    output logic                 OVERFLOW
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam int         CW     = $clog2(WIDTH + 1);

    logic [1:0]           state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     acc;
    logic [CW-1:0]        cnt;
    logic                 neg;
    logic                 sgn;

    logic                 mode_signed;
    logic [WIDTH-1:0]     x_abs;
    logic [WIDTH-1:0]     y_abs;
    logic [WIDTH-1:0]     add_term;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   prod_out;
    logic [WIDTH:0]       hi_sign;
    logic                 ovf;

    // Magnitudes fit in WIDTH unsigned bits, including the most-negative operand.
    always_comb begin
        mode_signed = SIGNED_EN && SIGNED;
        x_abs       = (mode_signed && X[WIDTH-1]) ? -X : X;
        y_abs       = (mode_signed && Y[WIDTH-1]) ? -Y : Y;
        add_term    = mplier[0] ? mcand : '0;
        sum         = {1'b0, acc} + {1'b0, add_term};
        product     = {acc, mplier};
        prod_out    = neg ? -product : product;
        hi_sign     = prod_out[2*WIDTH-1:WIDTH-1];
        if (sgn) begin
            ovf = ~((&hi_sign) | ~(|hi_sign));
        end else begin
            ovf = |prod_out[2*WIDTH-1:WIDTH];
        end
    end

    assign BUSY = (state != S_IDLE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            sgn      <= 1'b0;
            DONE     <= 1'b0;
            RESULT   <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        mcand  <= x_abs;
                        mplier <= y_abs;
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= mode_signed & (X[WIDTH-1] ^ Y[WIDTH-1]);
                        sgn    <= mode_signed;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    // {carry, acc, mplier} >> 1 after the conditional add
                    acc    <= sum[WIDTH:1];
                    mplier <= {sum[0], mplier[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    RESULT   <= prod_out;
                    OVERFLOW <= ovf;
                    DONE     <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: directed vectors push expectations, monitors pop them on DONE.
module tb_mult_seq;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start8, sgn8, busy8, done8, ovf8;
    logic [7:0]  x8, y8;
    logic [15:0] res8;
    logic        start16, sgn16, busy16, done16, ovf16;
    logic [15:0] x16, y16;
    logic [31:0] res16;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   done8_cnt = 0;
    int   done_snap;
    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;

    mult_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .CLK(clk), .RESET(rst), .START(start8), .SIGNED(sgn8), .X(x8), .Y(y8),
        .BUSY(busy8), .DONE(done8), .RESULT(res8), .OVERFLOW(ovf8)
    );

    mult_seq #(.WIDTH(16), .SIGNED_EN(1'b0)) dut16 (
        .CLK(clk), .RESET(rst), .START(start16), .SIGNED(sgn16), .X(x16), .Y(y16),
        .BUSY(busy16), .DONE(done16), .RESULT(res16), .OVERFLOW(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic note_fail(input string name, input string what);
        checks++;
        $display("FAIL %s: %s", name, what);
    endtask

    always @(negedge clk) begin
        if (busy8 && done8) note_fail("busy_done8", "BUSY and DONE high together");
        if (done8) begin
            done8_cnt++;
            if (q8.size() == 0) begin
                note_fail("unexpected_done8", "DONE with no accepted request outstanding");
            end else begin
                e8 = q8.pop_front();
                chk("result8", 64'(res8), 64'(e8.res[15:0]));
                chk("overflow8", 64'(ovf8), 64'(e8.ovf));
                chk("latency8", 64'(cyc), 64'(e8.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (busy16 && done16) note_fail("busy_done16", "BUSY and DONE high together");
        if (done16) begin
            if (q16.size() == 0) begin
                note_fail("unexpected_done16", "DONE with no accepted request outstanding");
            end else begin
                e16 = q16.pop_front();
                chk("result16", 64'(res16), 64'(e16.res));
                chk("overflow16", 64'(ovf16), 64'(e16.ovf));
                chk("latency16", 64'(cyc), 64'(e16.cyc));
            end
        end
    end

    // START sampled at the next edge (cyc+1); DONE visible WIDTH+1 edges later.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] r, input logic o);
        @(negedge clk);
        start8 = 1'b1; x8 = a; y8 = b; sgn8 = s;
        q8.push_back('{res: {16'h0, r}, ovf: o, cyc: cyc + 10});
        @(negedge clk);
        start8 = 1'b0; x8 = ~a; y8 = ~b; sgn8 = ~s;
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (q8.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0) begin
            note_fail("timeout8", "expected DONE not seen within 60 cycles");
            q8.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 64'(busy8), 64'h0);
        chk({tag, "_done"}, 64'(done8), 64'h0);
        chk({tag, "_result"}, 64'(res8), 64'h0);
        chk({tag, "_overflow"}, 64'(ovf8), 64'h0);
    endtask

    initial begin
        rst = 1'b0; start8 = 1'b1; sgn8 = 1'b0; x8 = 8'h0; y8 = 8'h0;
        start16 = 1'b0; sgn16 = 1'b0; x16 = 16'h0; y16 = 16'h0;

        // Reset held with START asserted
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            x8 = 8'($urandom); y8 = 8'($urandom); sgn8 = 1'($urandom);
        end
        check_reset_vals("reset_hold");
        rst = 1'b1; start8 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_release");

        // Unsigned
        issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        wait_idle8();
        issue8(8'h0F, 8'h03, 1'b0, 16'h002D, 1'b0);
        wait_idle8();

        // Signed, including most-negative squared and zero with negative sign
        issue8(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0);
        wait_idle8();
        issue8(8'h03, 8'hFB, 1'b1, 16'hFFF1, 1'b0);
        wait_idle8();
        issue8(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        wait_idle8();
        issue8(8'h03, 8'hFB, 1'b0, 16'h02F1, 1'b1);
        wait_idle8();
        issue8(8'h7F, 8'h7F, 1'b1, 16'h3F01, 1'b1);
        wait_idle8();
        issue8(8'h00, 8'h85, 1'b1, 16'h0000, 1'b0);
        wait_idle8();

        // START pulses while busy must be ignored
        done_snap = done8_cnt;
        issue8(8'h10, 8'h10, 1'b0, 16'h0100, 1'b1);
        start8 = 1'b1; x8 = 8'h55; y8 = 8'h66;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; x8 = 8'h77; y8 = 8'h99;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle8();
        repeat (20) @(negedge clk);
        chk("single_done", 64'(done8_cnt - done_snap), 64'd1);

        // START held high: accepted every WIDTH+2 cycles
        @(negedge clk);
        start8 = 1'b1; x8 = 8'h12; y8 = 8'h34; sgn8 = 1'b0;
        q8.push_back('{res: 32'h03A8, ovf: 1'b1, cyc: cyc + 10});
        @(negedge clk);
        x8 = 8'hAA; y8 = 8'hBB; sgn8 = 1'b1;
        repeat (9) @(negedge clk);
        x8 = 8'h0A; y8 = 8'h0B; sgn8 = 1'b0;
        q8.push_back('{res: 32'h006E, ovf: 1'b0, cyc: cyc + 10});
        @(negedge clk);
        x8 = 8'hCC; y8 = 8'hDD; sgn8 = 1'b0;
        repeat (9) @(negedge clk);
        x8 = 8'hFE; y8 = 8'h05; sgn8 = 1'b1;
        q8.push_back('{res: 32'hFFF6, ovf: 1'b0, cyc: cyc + 10});
        @(negedge clk);
        start8 = 1'b0; x8 = 8'h00; y8 = 8'h00;
        wait_idle8();

        // Asynchronous reset mid-operation aborts without DONE
        done_snap = done8_cnt;
        @(negedge clk);
        start8 = 1'b1; x8 = 8'h55; y8 = 8'h33; sgn8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy8), 64'h0);
        chk("abort_result", 64'(res8), 64'h0);
        chk("abort_overflow", 64'(ovf8), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 64'(done8_cnt - done_snap), 64'd0);
        issue8(8'h07, 8'h06, 1'b0, 16'h002A, 1'b0);
        wait_idle8();

        // WIDTH=16 with signed mode disabled: SIGNED ignored
        @(negedge clk);
        start16 = 1'b1; x16 = 16'hFFFF; y16 = 16'h0002; sgn16 = 1'b1;
        q16.push_back('{res: 32'h0001FFFE, ovf: 1'b1, cyc: cyc + 18});
        @(negedge clk);
        start16 = 1'b0;
        for (int n = 0; n < 60 && q16.size() != 0; n++) @(negedge clk);
        if (q16.size() != 0) note_fail("timeout16", "expected DONE not seen within 60 cycles");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Parametrised sequential multiplier; next generation of the ALU's 8-bit combinational array multiplier.
- Produces the full 2*WIDTH-bit product for unsigned or two's-complement operands, plus an overflow flag for the low half.
- Uses a radix-2 shift-add datapath and a START/BUSY/DONE handshake.
- Sits beside the ALU. The controller stalls on BUSY for multi-cycle MUL instructions.

Parameters:
- WIDTH, 8: operand width in bits, >= 2. Product width is 2*WIDTH.
- SIGNED_EN, 1: 1 honours the SIGNED input. 0 forces unsigned mode and ignores SIGNED.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only when not BUSY.
- SIGNED  input  1  1 = two's-complement operands; sampled with START.
- X  input  WIDTH  multiplicand; sampled with START.
- Y  input  WIDTH  multiplier; sampled with START.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse; RESULT and OVERFLOW are valid and new.
- RESULT  output  2*WIDTH  full product; held until overwritten by the next completion.
- OVERFLOW  output  1  low WIDTH bits of RESULT do not represent the true product in the selected mode; held with RESULT.

Behaviour:
- Reset: RESET low asynchronously forces:
  - state = IDLE, BUSY = 0, DONE = 0, RESULT = 0, OVERFLOW = 0;
  - iteration counter and internal registers = 0.
  - RESET low mid-operation aborts the operation; no DONE is produced.
- States: IDLE, CALC, FIN.
  - IDLE: START=1 at edge k latches X, Y, mode and moves to CALC; BUSY=1 from edge k.
    - Latch step (signed mode): store |X| and |Y| as WIDTH-bit unsigned values; record neg = X[msb] XOR Y[msb].
    - Latch step (unsigned mode): neg = 0.
    - Accumulator and counter clear at edge k.
  - CALC: one iteration per edge, edges k+1 .. k+WIDTH. Each iteration:
    - if the multiplier LSB = 1, add the multiplicand into the upper accumulator half, with carry kept in a (WIDTH+1)-bit add;
    - shift {carry, accumulator, multiplier} right by one.
    - The counter increments each iteration; after WIDTH iterations move to FIN.
  - FIN: entered at edge k+WIDTH. At edge k+WIDTH+1:
    - RESULT <= neg ? two's-complement negate(product) : product, truncated to 2*WIDTH bits;
    - OVERFLOW computed; DONE=1 for that cycle; BUSY=0; state -> IDLE.
- Latency: DONE high in the cycle after edge k+WIDTH+1, i.e. WIDTH+1 cycles after START is sampled. Fixed; no early termination on zero operands.
- Back-to-back: START=1 in the cycle DONE is high is sampled at the next edge as a new request (state is IDLE). Minimum issue interval is WIDTH+2 cycles.
- START while BUSY: ignored. X/Y/SIGNED changes while BUSY have no effect.
- OVERFLOW rules:
  - unsigned: RESULT[2W-1:W] != 0;
  - signed: RESULT[2W-1:W-1] not all-equal.
- Edge case: signed most-negative × most-negative (e.g. -128 × -128) yields the exact positive product, which fits in 2*WIDTH bits, with OVERFLOW=1.
- Zero product: RESULT=0, OVERFLOW=0, including when neg = 1; negate(0) = 0.
- DONE never asserts without a preceding accepted START. BUSY and DONE are never high together.

Test Plan:
1. Reset: hold RESET=0 with START=1 and random X/Y for 5 cycles -> BUSY=0, DONE=0, RESULT=0x0000, OVERFLOW=0. Release, START=0 -> outputs stay at reset values.
2. WIDTH=8 unsigned: X=0xFF, Y=0xFF, SIGNED=0 -> DONE exactly 9 cycles after START sampled, RESULT=0xFE01, OVERFLOW=1. Then X=0x0F, Y=0x03 -> RESULT=0x002D, OVERFLOW=0.
3. WIDTH=8 signed:
   - X=0xFF, Y=0xFF -> RESULT=0x0001, OVERFLOW=0;
   - X=0x03, Y=0xFB -> RESULT=0xFFF1, OVERFLOW=0;
   - X=0x80, Y=0x80 -> RESULT=0x4000, OVERFLOW=1.
   - Same 0x03/0xFB operands with SIGNED=0 -> RESULT=0x02F1, OVERFLOW=1.
4. Handshake:
   - START pulsed at cycles +2 and +5 of a running operation -> ignored; exactly one DONE.
   - START held high continuously -> DONE every 10 cycles, results match the operands presented on each accepting edge.
5. Reset mid-op: assert RESET=0 asynchronously, between clock edges, at iteration 4 -> BUSY=0 immediately, no DONE afterwards, RESULT=0. New op 0x07×0x06 after release -> 0x002A.
6. WIDTH=16, SIGNED_EN=0: X=0xFFFF, Y=0x0002 with SIGNED=1 -> treated as unsigned, RESULT=0x0001FFFE, OVERFLOW=1, latency 17 cycles.
